// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan code folder: merges E0/F0/E1 prefix sequences into single key
// events and queues them in a first-word-fall-through FIFO with valid/ready output.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          byte_valid,
    input  logic [7:0]                    byte_data,
    input  logic                          byte_err,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          seq_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_V  = FIFO_DEPTH[AW:0];
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_E0, ST_F0, ST_E0F0, ST_PAUSE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    pcnt_q, pcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ev_q, ev_d;
    logic [9:0]    evdat_q, evdat_d;
    logic          serr_q, serr_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [9:0]    mem_q [FIFO_DEPTH];

    logic          empty, full, pop, push_ok;
    logic [AW:0]   count;
    logic [9:0]    head;

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tmo_d   = tmo_q;
        ev_d    = 1'b0;
        evdat_d = evdat_q;
        serr_d  = 1'b0;
        if (byte_valid) begin
            tmo_d = '0;
            if (byte_err) begin
                state_d = ST_IDLE;
                serr_d  = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        case (byte_data)
                            8'hE0: state_d = ST_E0;
                            8'hF0: state_d = ST_F0;
                            8'hE1: begin
                                state_d = ST_PAUSE;
                                pcnt_d  = '0;
                            end
                            // Controller responses (ACK, BAT, echo, errors) carry no key.
                            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ;
                            default: begin
                                ev_d    = 1'b1;
                                evdat_d = {2'b00, byte_data};
                            end
                        endcase
                    end
                    ST_E0: begin
                        if (byte_data == 8'hF0) begin
                            state_d = ST_E0F0;
                        end else begin
                            ev_d    = 1'b1;
                            evdat_d = {2'b10, byte_data};
                            state_d = ST_IDLE;
                        end
                    end
                    ST_F0: begin
                        ev_d    = 1'b1;
                        evdat_d = {2'b01, byte_data};
                        state_d = ST_IDLE;
                    end
                    ST_E0F0: begin
                        ev_d    = 1'b1;
                        evdat_d = {2'b11, byte_data};
                        state_d = ST_IDLE;
                    end
                    ST_PAUSE: begin
                        if (pcnt_q == 3'd6) begin
                            ev_d    = 1'b1;
                            evdat_d = {2'b10, 8'h77};
                            state_d = ST_IDLE;
                        end else begin
                            pcnt_d = pcnt_q + 3'd1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
                serr_d  = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (count == DEPTH_V);
    assign pop     = !empty && evt_ready;
    assign push_ok = ev_q && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (ev_q && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            pcnt_q   <= '0;
            tmo_q    <= '0;
            ev_q     <= 1'b0;
            evdat_q  <= '0;
            serr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            tmo_q    <= tmo_d;
            ev_q     <= ev_d;
            evdat_q  <= evdat_d;
            serr_q   <= serr_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= evdat_q;
    end

    assign head       = empty ? 10'd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign evt_valid  = !empty;
    assign evt_ext    = head[9];
    assign evt_break  = head[8];
    assign evt_code   = head[7:0];
    assign fifo_count = count;
    assign overflow   = ovf_q;
    assign seq_err    = serr_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: prefix folding, Pause, FIFO full/overflow,
// timeout, byte errors and mid-sequence reset.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_err;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       seq_err;

    int n_cmp = 0;
    int n_mis = 0;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_err(byte_err),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
        .fifo_count(fifo_count), .overflow(overflow), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        byte_err   = err;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_err   = 1'b0;
    endtask

    task automatic pop;
        @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    task automatic expect_evt(input string tag, input logic ext, input logic brk, input logic [7:0] code);
        chk({tag, ".valid"}, 32'(evt_valid), 32'd1);
        chk({tag, ".rec"}, 32'({evt_ext, evt_break, evt_code}), 32'({ext, brk, code}));
        pop();
    endtask

    initial begin
        int k;
        resetn = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_err = 1'b0; evt_ready = 1'b0;
        wait_n(3);
        chk("rst.outs", 32'({evt_valid, evt_code, evt_ext, evt_break, fifo_count, overflow, seq_err}), 32'd0);
        resetn = 1'b1;
        wait_n(1);
        chk("rst.count", 32'(fifo_count), 32'd0);

        // Single make code with exact latency.
        send(8'h1C);
        chk("lat.n1", 32'(evt_valid), 32'd0);
        wait_n(1);
        expect_evt("make1c", 1'b0, 1'b0, 8'h1C);
        chk("pop.valid", 32'(evt_valid), 32'd0);
        chk("pop.count", 32'(fifo_count), 32'd0);

        // Break, extended break, extended make.
        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h74);
        send(8'hE0); send(8'h75);
        wait_n(2);
        chk("seq.count", 32'(fifo_count), 32'd3);
        expect_evt("brk1c", 1'b0, 1'b1, 8'h1C);
        expect_evt("ebrk74", 1'b1, 1'b1, 8'h74);
        expect_evt("emk75", 1'b1, 1'b0, 8'h75);

        // Pause sequence folds into one event; ACK byte yields none.
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        wait_n(2);
        chk("pause.count", 32'(fifo_count), 32'd1);
        expect_evt("pause", 1'b1, 1'b0, 8'h77);
        chk("pause.empty", 32'(fifo_count), 32'd0);
        send(8'hFA);
        wait_n(3);
        chk("fa.count", 32'(fifo_count), 32'd0);
        chk("fa.valid", 32'(evt_valid), 32'd0);

        // Fill past capacity, then push and pop in the same cycle while full.
        for (int i = 1; i <= 9; i++) send(8'(i));
        wait_n(2);
        chk("full.count", 32'(fifo_count), 32'd8);
        chk("full.ovf", 32'(overflow), 32'd1);
        chk("full.head", 32'(evt_code), 32'h01);
        @(negedge clk);
        byte_valid = 1'b1; byte_data = 8'h0A;
        @(negedge clk);
        byte_valid = 1'b0; evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        chk("fullpp.count", 32'(fifo_count), 32'd8);
        for (int i = 2; i <= 8; i++) expect_evt("drain", 1'b0, 1'b0, 8'(i));
        expect_evt("drain0a", 1'b0, 1'b0, 8'h0A);
        chk("drain.count", 32'(fifo_count), 32'd0);
        chk("drain.ovf", 32'(overflow), 32'd1);

        // Timeout after a lone E0.
        send(8'hE0);
        k = 0;
        while (!seq_err && k < 3 * TMO) begin
            @(negedge clk);
            k++;
        end
        chk("tmo.cycles", 32'(k), 32'(TMO));
        wait_n(1);
        chk("tmo.pulse", 32'(seq_err), 32'd0);
        send(8'h1C);
        wait_n(1);
        expect_evt("tmo.next", 1'b0, 1'b0, 8'h1C);

        // Byte error mid-sequence.
        send(8'hF0);
        send(8'h1C, 1'b1);
        chk("err.pulse", 32'(seq_err), 32'd1);
        wait_n(1);
        chk("err.pulse_end", 32'(seq_err), 32'd0);
        wait_n(2);
        chk("err.count", 32'(fifo_count), 32'd0);
        send(8'h1C);
        wait_n(1);
        expect_evt("err.next", 1'b0, 1'b0, 8'h1C);

        // Reset mid-sequence with events queued and overflow set.
        send(8'h11); send(8'h12); send(8'h13); send(8'hE0);
        wait_n(2);
        chk("prerst.count", 32'(fifo_count), 32'd3);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("mrst.count", 32'(fifo_count), 32'd0);
        chk("mrst.ovf", 32'(overflow), 32'd0);
        chk("mrst.valid", 32'(evt_valid), 32'd0);
        send(8'h1C);
        wait_n(1);
        expect_evt("mrst.next", 1'b0, 1'b0, 8'h1C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
